// File: rtl/cdc_pulse_scheduler.sv
// Schedules single-cycle pulses from N_REQ requesters onto one shared fast-to-slow
// pulse synchronizer: round-robin grant, wait for the slow-domain acknowledge, then a hold-off gap.
`timescale 1ns/1ps
module cdc_pulse_scheduler #(
  parameter int N_REQ      = 4,
  parameter int GAP_CYCLES = 3,
  parameter int TIMEOUT    = 16
) (
  input  logic                                       clk,
  input  logic                                       reset,
  input  logic [N_REQ-1:0]                           req,
  input  logic                                       ack,
  input  logic                                       err_clr,
  output logic                                       pulse,
  output logic [(N_REQ > 1 ? $clog2(N_REQ) : 1)-1:0] pulse_id,
  output logic [N_REQ-1:0]                           pending,
  output logic [N_REQ-1:0]                           coalesced,
  output logic                                       timeout_err,
  output logic                                       busy,
  output logic [1:0]                                 fsm_state
);

  localparam int IDW  = N_REQ > 1 ? $clog2(N_REQ) : 1;
  localparam int CMAX = TIMEOUT > GAP_CYCLES ? TIMEOUT : GAP_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  // Handshake: a req pulse is latched into pending and is never dropped; each pulse
  // is closed by one ack cycle while in WAIT_ACK (or by the timeout), ack elsewhere is ignored.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [IDW-1:0]   rr_ptr;
  logic             grant_vld;
  logic [IDW-1:0]   grant_idx;
  logic [IDW-1:0]   cand;
  logic [N_REQ-1:0] grant_clr;
  logic [N_REQ-1:0] coal_set;
  logic             to_fire;
  int               idx;

  assign fsm_state = state;

  // Round-robin search from rr_ptr; iterating downwards lets the nearest candidate win.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = IDW'(idx);
      if (pending[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  always_comb begin
    grant_clr = '0;
    if (state == IDLE && grant_vld) grant_clr[grant_idx] = 1'b1;
    coal_set = req & pending & ~grant_clr;
    to_fire  = (state == WAIT_ACK) && !ack && (cnt == CW'(TIMEOUT - 1));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      rr_ptr      <= '0;
      pulse       <= 1'b0;
      pulse_id    <= '0;
      pending     <= '0;
      coalesced   <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      pending   <= req | (pending & ~grant_clr);
      coalesced <= coal_set | (coalesced & ~{N_REQ{err_clr}});
      // A new timeout in the same cycle as err_clr keeps the flag set.
      if (to_fire)      timeout_err <= 1'b1;
      else if (err_clr) timeout_err <= 1'b0;

      case (state)
        IDLE: begin
          if (grant_vld) begin
            state    <= ISSUE;
            pulse    <= 1'b1;
            busy     <= 1'b1;
            pulse_id <= grant_idx;
            rr_ptr   <= (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT_ACK;
          pulse <= 1'b0;
          cnt   <= '0;
        end
        WAIT_ACK: begin
          if (ack || to_fire) begin
            state <= GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == CW'(GAP_CYCLES - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          pulse <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cdc_pulse_scheduler.sv
// Bench for cdc_pulse_scheduler: directed scenarios plus random traffic, compared each
// cycle against a timestamp-based reference model and a pulse_id scoreboard queue.
`timescale 1ns/1ps
module tb_cdc_pulse_scheduler;
  localparam int N   = 4;
  localparam int GAP = 3;
  localparam int TMO = 16;

  // clock / reset
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] req = '0;
  logic       ack = 1'b0;
  logic       err_clr = 1'b0;
  logic       pulse;
  logic [1:0] pulse_id;
  logic [3:0] pending;
  logic [3:0] coalesced;
  logic       timeout_err;
  logic       busy;
  logic [1:0] fsm_state;

  always #5 clk = ~clk;

  cdc_pulse_scheduler #(.N_REQ(N), .GAP_CYCLES(GAP), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req(req), .ack(ack), .err_clr(err_clr),
    .pulse(pulse), .pulse_id(pulse_id), .pending(pending), .coalesced(coalesced),
    .timeout_err(timeout_err), .busy(busy), .fsm_state(fsm_state)
  );

  int checks = 0;
  int failures = 0;

  // scoreboard and reference model state
  logic [1:0] exp_q[$];
  int         edge_n = 0;
  int         g_edge = -1;
  int         r_edge = -1;
  logic [3:0] m_pend = '0;
  logic [3:0] m_coal = '0;
  logic       m_terr = 1'b0;
  int         m_rr = 0;
  logic [1:0] m_id = '0;
  logic       m_pulse = 1'b0;
  logic       m_busy = 1'b0;

  int         ack_delay = -1;
  bit         ack_rand = 1'b0;
  int         since_pulse = 1000;
  int         pl_edge[$];
  logic [1:0] pl_id[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    g_edge = -1; r_edge = -1;
    m_pend = '0; m_coal = '0; m_terr = 1'b0;
    m_rr = 0; m_id = '0; m_pulse = 1'b0; m_busy = 1'b0;
    exp_q.delete();
  endtask

  // Transfer timeline: grant at edge g, ack accepted on edges g+2..g+TMO+1 (else timeout
  // at g+TMO+1), resolution edge r, idle again from edge r+GAP, next grant possible at r+GAP+1.
  task automatic model_step(input logic [3:0] r, input logic a, input logic c);
    logic [3:0] clr_b;
    logic       idle_before;
    logic       terr_set;
    int         gi;
    edge_n++;
    clr_b = '0;
    terr_set = 1'b0;
    gi = 0;
    idle_before = (g_edge < 0) || (r_edge >= 0 && edge_n >= r_edge + GAP + 1);
    if (g_edge >= 0 && r_edge < 0 && edge_n >= g_edge + 2) begin
      if (a) r_edge = edge_n;
      else if (edge_n == g_edge + TMO + 1) begin
        r_edge = edge_n;
        terr_set = 1'b1;
      end
    end
    if (idle_before && m_pend != 4'b0) begin
      for (int k = 0; k < N; k++) begin
        gi = (m_rr + k) % N;
        if (m_pend[gi]) break;
      end
      g_edge = edge_n;
      r_edge = -1;
      clr_b[gi] = 1'b1;
      m_rr = (gi + 1) % N;
      m_id = 2'(gi);
      exp_q.push_back(2'(gi));
    end
    m_coal  = (c ? 4'b0 : m_coal) | (r & m_pend & ~clr_b);
    m_terr  = terr_set | (m_terr & ~c);
    m_pend  = r | (m_pend & ~clr_b);
    m_pulse = (g_edge == edge_n);
    m_busy  = (g_edge >= 0) && (r_edge < 0 || edge_n < r_edge + GAP);
  endtask

  task automatic compare_all();
    check("pulse", 32'(pulse), 32'(m_pulse));
    check("busy", 32'(busy), 32'(m_busy));
    check("pending", 32'(pending), 32'(m_pend));
    check("coalesced", 32'(coalesced), 32'(m_coal));
    check("timeout_err", 32'(timeout_err), 32'(m_terr));
    check("pulse_id", 32'(pulse_id), 32'(m_id));
    if (pulse) begin
      check("sb_expected_pulse", 32'(exp_q.size() > 0), 32'd1);
      if (exp_q.size() > 0) check("sb_pulse_id", 32'(pulse_id), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulse"}, 32'(pulse), 32'd0);
    check({tag, "_pulse_id"}, 32'(pulse_id), 32'd0);
    check({tag, "_pending"}, 32'(pending), 32'd0);
    check({tag, "_coalesced"}, 32'(coalesced), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_state"}, 32'(fsm_state), 32'd0);
  endtask

  // driver: called at a negedge, returns at the next negedge
  task automatic cycle(input logic [3:0] r, input logic c);
    logic a;
    if (ack_rand) a = ($urandom_range(0, 7) == 0);
    else          a = (ack_delay >= 0 && since_pulse == ack_delay);
    req = r; ack = a; err_clr = c;
    @(posedge clk);
    model_step(r, a, c);
    #1;
    compare_all();
    if (pulse) begin
      since_pulse = 0;
      pl_edge.push_back(edge_n);
      pl_id.push_back(pulse_id);
    end else begin
      since_pulse++;
    end
    @(negedge clk);
    req = '0; ack = 1'b0; err_clr = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(4'b0, 1'b0);
  endtask

  // asynchronous reset, checked before any clock edge and again while held over an edge
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_zero("rst_async");
    @(posedge clk);
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    reset = 1'b0;
    since_pulse = 1000;
    pl_edge.delete();
    pl_id.delete();
  endtask

  initial begin
    @(negedge clk);
    do_reset();

    // single request, ack two cycles after the pulse
    ack_delay = 2;
    cycle(4'b0100, 1'b0);
    idle(12);
    check("t1_npulse", 32'(pl_id.size()), 32'd1);
    if (pl_id.size() > 0) check("t1_id", 32'(pl_id[0]), 32'd2);
    check("t1_pending", 32'(pending), 32'd0);

    // all requesters at once, immediate ack
    do_reset();
    ack_delay = 1;
    cycle(4'b1111, 1'b0);
    idle(26);
    check("t2_npulse", 32'(pl_id.size()), 32'd4);
    for (int i = 0; i < pl_id.size() && i < 4; i++) begin
      check("t2_id", 32'(pl_id[i]), 32'(i));
      if (i > 0) check("t2_spacing", 32'(pl_edge[i] - pl_edge[i-1]), 32'(GAP + 3));
    end

    // coalescing while requester 0 holds the synchronizer
    do_reset();
    ack_delay = 1;
    cycle(4'b0001, 1'b0);
    cycle(4'b0010, 1'b0);
    cycle(4'b0010, 1'b0);
    idle(14);
    check("t3_npulse", 32'(pl_id.size()), 32'd2);
    if (pl_id.size() > 1) check("t3_id", 32'(pl_id[1]), 32'd1);
    check("t3_coalesced", 32'(coalesced), 32'b0010);
    cycle(4'b0, 1'b1);
    check("t3_coal_clr", 32'(coalesced), 32'd0);

    // missing acknowledge, then the next pending requester is served
    do_reset();
    ack_delay = -1;
    cycle(4'b0001, 1'b0);
    cycle(4'b0100, 1'b0);
    idle(22);
    check("t4_terr", 32'(timeout_err), 32'd1);
    check("t4_npulse", 32'(pl_id.size()), 32'd2);
    if (pl_id.size() > 1) begin
      check("t4_id", 32'(pl_id[1]), 32'd2);
      check("t4_spacing", 32'(pl_edge[1] - pl_edge[0]), 32'(TMO + GAP + 2));
    end
    ack_delay = 1;
    idle(10);
    cycle(4'b0, 1'b1);
    check("t4_terr_clr", 32'(timeout_err), 32'd0);

    // re-request at the granting edge
    do_reset();
    ack_delay = 1;
    cycle(4'b0001, 1'b0);
    cycle(4'b0001, 1'b0);
    check("t5_pend_kept", 32'(pending), 32'b0001);
    idle(14);
    check("t5_npulse", 32'(pl_id.size()), 32'd2);
    if (pl_id.size() > 1) check("t5_id", 32'(pl_id[1]), 32'd0);

    // reset while waiting for an acknowledge
    do_reset();
    ack_delay = -1;
    cycle(4'b0011, 1'b0);
    idle(3);
    check("t6_busy_pre", 32'(busy), 32'd1);
    do_reset();
    idle(30);
    check("t6_no_pulse", 32'(pl_id.size()), 32'd0);

    // random traffic with random acks, err_clr and one mid-run reset
    do_reset();
    ack_rand = 1'b1;
    for (int i = 0; i < 400; i++) begin
      logic [3:0] rv;
      rv = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0;
      if (i == 200) do_reset();
      cycle(rv, ($urandom_range(0, 15) == 0));
    end
    ack_rand = 1'b0;
    ack_delay = 1;
    idle(120);
    check("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cdc_pulse_scheduler.md
CDC_PULSE_SCHEDULER -- requirements
Module: cdc_pulse_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters sharing one fast-to-slow pulse synchronizer.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 3, giving the hold-off cycles after each acknowledged or timed-out pulse (1.5 x 100/50).
REQ-003 The block SHALL have parameter TIMEOUT, default 16, giving the maximum WAIT_ACK cycles before abandoning an acknowledge.
REQ-004 The block SHALL have port clk, input, 1 bit, single clock for the whole block (fast domain).
REQ-005 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-006 The block SHALL have port req, input, N_REQ bits, per-requester single-cycle pulse requests.
REQ-007 The block SHALL have port ack, input, 1 bit, single-cycle acknowledge from the slow domain, already synchronized to clk.
REQ-008 The block SHALL have port err_clr, input, 1 bit, which clears the sticky error flags.
REQ-009 The block SHALL have port pulse, output, 1 bit, single-cycle pulse to the synchronizer input.
REQ-010 The block SHALL have port pulse_id, output, clog2(N_REQ) bits, index of the most recently granted requester.
REQ-011 The block SHALL have port pending, output, N_REQ bits, outstanding request flags.
REQ-012 The block SHALL have port coalesced, output, N_REQ bits, sticky flags marking requests merged into an already pending one.
REQ-013 The block SHALL have port timeout_err, output, 1 bit, sticky flag for a missing acknowledge.
REQ-014 The block SHALL have port busy, output, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-015 pending[i] SHALL be set at the clk edge sampling req[i]=1.
REQ-016 pending[i] SHALL be cleared at the edge that grants requester i, unless req[i]=1 at that same edge, in which case it stays set.
REQ-017 coalesced[i] SHALL be set when req[i]=1 is sampled while pending[i]=1 and pending[i] is not being cleared at that edge.
REQ-018 The FSM SHALL have exactly the states IDLE, ISSUE, WAIT_ACK and GAP; all outputs SHALL be registered.
REQ-019 In IDLE with pending nonzero, the FSM SHALL grant one requester, load pulse_id and move to ISSUE; req[i] sampled at edge E gives pulse high in the cycle after E+1 (two-edge latency).
REQ-020 Arbitration SHALL be round-robin: search starts at last_grant+1 mod N_REQ; after reset, index 0 has highest priority.
REQ-021 ISSUE SHALL last exactly one cycle with pulse=1, then move to WAIT_ACK; pulse SHALL be 0 in all other states.
REQ-022 In WAIT_ACK, ack=1 SHALL move the FSM to GAP; after TIMEOUT consecutive WAIT_ACK cycles without ack, the FSM SHALL set timeout_err and move to GAP.
REQ-023 ack SHALL be ignored in IDLE, ISSUE and GAP.
REQ-024 GAP SHALL last exactly GAP_CYCLES cycles, then the FSM SHALL return to IDLE.
REQ-025 With an immediate ack, consecutive pulses SHALL be spaced exactly GAP_CYCLES+3 cycles apart (6 at the defaults).
REQ-026 err_clr SHALL clear coalesced and timeout_err; a set event in the same cycle SHALL win over err_clr.
REQ-027 pulse_id SHALL hold its last granted value until the next grant.

Reset
REQ-028 While reset=1, the block SHALL immediately force state=IDLE, pulse=0, pulse_id=0, pending=0, coalesced=0, timeout_err=0, busy=0, round-robin pointer to index 0 first, and all counters to 0.
REQ-029 Reset asserted mid-operation (any state) SHALL abandon the in-flight transfer; no pulse SHALL be emitted after release until a new req is sampled.

Verification
REQ-030 Single request: req=4'b0100 for one cycle, ack 2 cycles after pulse -> exactly one pulse with pulse_id=2, busy high from ISSUE through GAP, pending=0 afterwards.
REQ-031 All requesters at once: req=4'b1111 in one cycle, ack in the first WAIT_ACK cycle each time -> pulses with ids 0,1,2,3 in order, 6 cycles apart.
REQ-032 Coalescing: req[1] pulsed twice before its grant -> one pulse with id 1 and coalesced=4'b0010; then err_clr -> coalesced=0.
REQ-033 Missing ack: no ack after a pulse -> timeout_err=1 after 16 WAIT_ACK cycles, then 3 GAP cycles, then the next pending requester is served.
REQ-034 Re-request at grant: req[0]=1 at the granting edge of id 0 -> pending[0] stays 1 and a second pulse with id 0 follows.
REQ-035 Reset in WAIT_ACK: reset asserted -> all outputs are 0 with no clock edge, and no pulse occurs after release without a new req.
